// File: rtl/echo_wb_ctrl.sv
// echo_wb_ctrl: sequencer and write-back controller for the voice-corruptor echo loop.
//
// Owns the circular delay RAM. For every accepted sample tick it reads the delayed echo
// sample, strobes the gain stage (t1..t4), mixes the gain result G with the live input,
// saturates the sum to 10 bits, emits it on y_out and writes half of it back into the RAM.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   sample_tick            one-cycle pulse per audio sample
//   x_in, mode, delay_len  live sample, echo path select, echo delay (taken on accepted tick)
//   G                      signed gain-stage result, valid the cycle after the t1/t2/t3 strobe
//   ram_q                  delay RAM read data (synchronous RAM, 1-cycle latency)
//   t1, t2, t3, t4         gain-stage strobes (t4 clears the gain stage)
//   ram_addr, ram_we,
//   ram_wdata              delay RAM address (registered), write enable, write data
//   y_out, y_valid         mixed output sample (held) and its one-cycle update pulse
//   busy, overrun          sample in flight; sticky flag for a tick seen while busy
module echo_wb_ctrl #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_tick,
    input  logic signed [9:0]        x_in,
    input  logic        [1:0]        mode,
    input  logic        [ADDR_W-1:0] delay_len,
    input  logic signed [9:0]        G,
    input  logic        [8:0]        ram_q,
    output logic                     t1,
    output logic                     t2,
    output logic                     t3,
    output logic                     t4,
    output logic        [ADDR_W-1:0] ram_addr,
    output logic                     ram_we,
    output logic        [8:0]        ram_wdata,
    output logic signed [9:0]        y_out,
    output logic                     y_valid,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic [2:0] {
        StIdle,
        StRaddr,
        StStrobe,
        StCapt,
        StWrite,
        StClr
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic signed [9:0]     x_q, x_d;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
    logic signed [9:0]     y_q, y_d;
    logic                  overrun_q, overrun_d;

    logic signed [9:0]     g_sel;
    logic signed [10:0]    sum;

    // Bypass mode ignores the gain stage entirely.
    assign g_sel = (mode_q == 2'b11) ? 10'sd0 : G;
    assign sum   = {x_q[9], x_q} + {g_sel[9], g_sel};

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        x_d        = x_q;
        mode_d     = mode_q;
        ram_addr_d = ram_addr_q;
        y_d        = y_q;
        overrun_d  = overrun_q | (sample_tick && (state_q != StIdle));
        t1         = 1'b0;
        t2         = 1'b0;
        t3         = 1'b0;
        t4         = 1'b0;
        ram_we     = 1'b0;
        ram_wdata  = 9'd0;
        y_valid    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sample_tick) begin
                    x_d        = x_in;
                    mode_d     = mode;
                    // Read address is registered so it is on the RAM pins during RADDR.
                    ram_addr_d = wr_ptr_q - delay_len;
                    state_d    = StRaddr;
                end
            end
            StRaddr: begin
                state_d = StStrobe;
            end
            StStrobe: begin
                t1      = (mode_q == 2'b00);
                t2      = (mode_q == 2'b01);
                t3      = (mode_q == 2'b10);
                state_d = StCapt;
            end
            StCapt: begin
                // Overflow iff the two top bits of the 11-bit sum disagree.
                if (sum[10] != sum[9]) begin
                    y_d = sum[10] ? -10'sd512 : 10'sd511;
                end else begin
                    y_d = sum[9:0];
                end
                ram_addr_d = wr_ptr_q;
                state_d    = StWrite;
            end
            StWrite: begin
                y_valid   = 1'b1;
                ram_we    = 1'b1;
                // Arithmetic shift right by one of a 10-bit value fits 9 bits exactly.
                ram_wdata = y_q[9:1];
                state_d   = StClr;
            end
            StClr: begin
                t4       = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            x_q        <= '0;
            mode_q     <= '0;
            ram_addr_q <= '0;
            y_q        <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            x_q        <= x_d;
            mode_q     <= mode_d;
            ram_addr_q <= ram_addr_d;
            y_q        <= y_d;
            overrun_q  <= overrun_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign y_out    = y_q;
    assign busy     = (state_q != StIdle);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_echo_wb_ctrl.sv
// Self-checking bench for echo_wb_ctrl: models the delay RAM and a simple gain stage
// (t1: q/2, t2: 2q, t3: q/4, t4: clear), and checks every sample against a reference
// echo-buffer model computed from the mixing/saturation rules.
module tb_echo_wb_ctrl;

    localparam int AW = 5;
    localparam int N  = 1 << AW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sample_tick = 1'b0;
    logic signed [9:0]    x_in = '0;
    logic        [1:0]    mode = '0;
    logic        [AW-1:0] delay_len = '0;
    logic signed [9:0]    G;
    logic        [8:0]    ram_q;
    logic                 t1, t2, t3, t4;
    logic        [AW-1:0] ram_addr;
    logic                 ram_we;
    logic        [8:0]    ram_wdata;
    logic signed [9:0]    y_out;
    logic                 y_valid, busy, overrun;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    echo_wb_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .x_in(x_in), .mode(mode),
        .delay_len(delay_len), .G(G), .ram_q(ram_q), .t1(t1), .t2(t2), .t3(t3), .t4(t4),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .y_out(y_out),
        .y_valid(y_valid), .busy(busy), .overrun(overrun)
    );

    // Delay RAM with a bench-side preload port.
    logic [8:0]    ram [N];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [8:0]    pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_q <= ram[ram_addr];
    end

    function automatic logic signed [9:0] gain(input int sel, input logic [8:0] q);
        int qi;
        qi = int'($signed(q));
        case (sel)
            0:       return 10'(qi >>> 1);
            1:       return 10'(qi * 2);
            default: return 10'(qi >>> 2);
        endcase
    endfunction

    always @(posedge clk) begin
        if (t1) G <= gain(0, ram_q);
        else if (t2) G <= gain(1, ram_q);
        else if (t3) G <= gain(2, ram_q);
        else if (t4) G <= '0;
    end

    // Reference model: echo buffer contents and write pointer.
    int m_mem [N];
    int m_ptr = 0;

    function automatic int wrapn(input int a);
        return ((a % N) + N) % N;
    endfunction

    function automatic int flags();
        return int'({busy, t1, t2, t3, t4, ram_we, y_valid});
    endfunction

    function automatic int zero_bits();
        return $countones({t1, t2, t3, t4, ram_we, y_valid, busy, overrun, y_out, ram_addr,
                           ram_wdata});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic preload(input int addr, input int val);
        pre_en   = 1'b1;
        pre_addr = AW'(addr);
        pre_data = 9'(val);
        @(negedge clk);
        pre_en = 1'b0;
        m_mem[addr] = val;
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge of cycle 6 (idle again).
    task automatic run_sample(input int x, input int md, input int dl, input bit extra);
        int raddr, q, g, s, y, wd, stb;
        raddr = wrapn(m_ptr - dl);
        q     = m_mem[raddr];
        case (md)
            0:       begin g = q >>> 1; stb = 3'b100; end
            1:       begin g = q * 2;   stb = 3'b010; end
            2:       begin g = q >>> 2; stb = 3'b001; end
            default: begin g = 0;       stb = 3'b000; end
        endcase
        s  = x + g;
        y  = (s > 511) ? 511 : ((s < -512) ? -512 : s);
        wd = y >>> 1;

        sample_tick = 1'b1;
        x_in = 10'(x);
        mode = 2'(md);
        delay_len = AW'(dl);
        @(negedge clk);
        // Inputs scrambled after acceptance must not matter.
        sample_tick = 1'b0;
        x_in = 10'($urandom);
        mode = 2'($urandom);
        delay_len = AW'($urandom);
        chk("c1 flags", flags(), 7'b1000000);
        chk("c1 read addr", int'(ram_addr), raddr);
        @(negedge clk);
        chk("c2 strobes", flags(), {1'b1, 3'(stb), 3'b000});
        @(negedge clk);
        chk("c3 flags", flags(), 7'b1000000);
        if (extra) sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("c4 flags", flags(), 7'b1000011);
        chk("c4 y_out", int'(y_out), y);
        chk("c4 write addr", int'(ram_addr), m_ptr);
        chk("c4 wdata", int'($signed(ram_wdata)), wd);
        @(negedge clk);
        chk("c5 flags", flags(), 7'b1000100);
        @(negedge clk);
        chk("c6 flags", flags(), 0);
        chk("c6 y_out held", int'(y_out), y);
        m_mem[m_ptr] = wd;
        m_ptr = wrapn(m_ptr + 1);
    endtask

    typedef struct {
        int x;
        int md;
        int dl;
        int q;
        int y;
        int wd;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int a, saved, wa;
        vecs[0] = '{100, 3, 0, 77, 100, 50};
        vecs[1] = '{30, 0, 3, 40, 50, 25};
        vecs[2] = '{500, 0, 1, 200, 511, 255};
        vecs[3] = '{-500, 0, 2, -200, -512, -256};
        vecs[4] = '{10, 1, 4, 50, 110, 55};
        vecs[5] = '{-7, 2, 5, -40, -17, -9};
        vecs[6] = '{511, 1, 31, 255, 511, 255};
        vecs[7] = '{-1, 3, 0, 0, -1, -1};
        vecs[8] = '{-512, 1, 6, -256, -512, -256};

        // Clear RAM while in reset.
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            preload(i, 0);
        end
        #1;
        chk("reset outputs zero", zero_bits(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle outputs zero", zero_bits(), 0);

        // First bypass tick writes 50 at address 0, then advance pointer to 10.
        run_sample(100, 3, 0, 1'b0);
        chk("first write mem[0]", int'($signed(ram[0])), 50);
        for (int i = 1; i < 10; i++) run_sample(i * 3, 3, 0, 1'b0);

        // Echo path: RAM[7]=40, delay 3 from pointer 10, G=20.
        preload(7, 40);
        run_sample(30, 0, 3, 1'b0);
        chk("echo y_out", int'(y_out), 50);
        chk("echo mem[10]", int'($signed(ram[10])), 25);

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            a  = wrapn(m_ptr - vecs[i].dl);
            wa = m_ptr;
            preload(a, vecs[i].q);
            run_sample(vecs[i].x, vecs[i].md, vecs[i].dl, 1'b0);
            chk($sformatf("vec%0d y_out", i), int'(y_out), vecs[i].y);
            chk($sformatf("vec%0d mem", i), int'($signed(ram[wa])), vecs[i].wd);
        end

        // Overrun: second tick in cycle 3 is ignored, flag is sticky.
        chk("overrun clear", int'(overrun), 0);
        run_sample(-20, 2, 1, 1'b1);
        chk("overrun set", int'(overrun), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no second sample", flags(), 0);
        end
        chk("overrun sticky", int'(overrun), 1);

        // Async reset during WRITE suppresses the RAM write.
        wa = m_ptr;
        preload(wa, -5);
        sample_tick = 1'b1;
        x_in = 10'sd123;
        mode = 2'b11;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset in WRITE", flags(), 7'b1000011);
        saved = int'(ram_addr);
        #2 rst_n = 1'b0;
        #1 chk("async reset zero", zero_bits(), 0);
        @(negedge clk);
        chk("write suppressed", int'($signed(ram[saved])), -5);
        rst_n = 1'b1;
        m_ptr = 0;
        @(negedge clk);

        // Wrap: N bypass ticks from pointer 0, then delay 0 reads the first word back.
        run_sample(200, 3, 0, 1'b0);
        for (int i = 1; i < N; i++) run_sample(i, 3, 0, 1'b0);
        run_sample(3, 0, 0, 1'b0);
        chk("wrap readback y_out", int'(y_out), 53);
        chk("wrap writes addr 0", int'($signed(ram[0])), 26);

        // Randomized samples against the reference model.
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(2)) @(negedge clk);
            run_sample(int'($urandom_range(1023)) - 512, int'($urandom_range(3)),
                       int'($urandom_range(N - 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
